// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared encodings for the iterative M-extension multiply/divide unit
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

    localparam logic [6:0] c_funct7_m   = 7'b000_0001;

    localparam logic [2:0] c_f3_mul     = 3'b000;
    localparam logic [2:0] c_f3_mulh    = 3'b001;
    localparam logic [2:0] c_f3_mulhsu  = 3'b010;
    localparam logic [2:0] c_f3_mulhu   = 3'b011;
    localparam logic [2:0] c_f3_div     = 3'b100;
    localparam logic [2:0] c_f3_divu    = 3'b101;
    localparam logic [2:0] c_f3_rem     = 3'b110;
    localparam logic [2:0] c_f3_remu    = 3'b111;

    localparam logic [3:0] ALUCtrl_mul  = 4'b0111;

    typedef logic [1:0] state_t;
    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_calc = 2'd1;
    localparam state_t c_st_done = 2'd2;

    // MULH and MULHSU share the M-extension funct7 but have no datapath here
    function automatic logic is_supported(input logic [9:0] funct);
        return (funct[9:3] == c_funct7_m) &&
               (funct[2:0] != c_f3_mulh) && (funct[2:0] != c_f3_mulhsu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_core
// Brief    : Unsigned shift-add multiply / restoring divide datapath, one step per cycle
// Revision : 1.0
// ============================================================================
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;

    // Multiply: {hi,lo} shifts right, lo starts as the multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b};
        if (i_is_div) begin
            if (!w_diff[XLEN]) begin
                w_hi_nxt = w_diff[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= i_hi;
            r_lo <= i_lo;
            r_b  <= i_b;
        end else if (i_step) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV M-extension multiply/divide unit with FSM and sign fix-up
// Revision : 1.0
// ============================================================================
module muldiv_unit
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] result_o
);
    import muldiv_pkg::*;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(XLEN - 1);

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_op;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_illegal;
    logic [XLEN-1:0] r_result;

    logic [2:0]      w_f3;
    logic            w_is_div;
    logic            w_signed;
    logic            w_rs1_neg;
    logic            w_rs2_neg;
    logic            w_dz;
    logic            w_req;
    logic            w_accept;
    logic            w_reject;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic [XLEN-1:0] w_ld_hi;
    logic [XLEN-1:0] w_ld_lo;
    logic [XLEN-1:0] w_ld_b;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic [XLEN-1:0] w_final;

    assign w_f3      = funct_i[2:0];
    assign w_is_div  = w_f3[2];
    assign w_signed  = w_is_div & ~w_f3[0];
    assign w_rs1_neg = w_signed & rs1_i[XLEN-1];
    assign w_rs2_neg = w_signed & rs2_i[XLEN-1];
    assign w_abs1    = w_rs1_neg ? -rs1_i : rs1_i;
    assign w_abs2    = w_rs2_neg ? -rs2_i : rs2_i;
    assign w_dz      = w_is_div && (rs2_i == '0);

    // Flush outranks start: a flushed instruction is neither accepted nor flagged
    assign w_req     = (r_state == c_st_idle) && start_i && !flush_i;
    assign w_accept  = w_req && is_supported(funct_i);
    assign w_reject  = w_req && !is_supported(funct_i);

    // Divide-by-zero preloads the architectural answer so DONE can read it unchanged
    always_comb begin
        w_ld_hi = '0;
        w_ld_lo = rs2_i;
        w_ld_b  = rs1_i;
        if (w_dz) begin
            w_ld_hi = rs1_i;
            w_ld_lo = '1;
        end else if (w_is_div) begin
            w_ld_lo = w_abs1;
            w_ld_b  = w_abs2;
        end
    end

    muldiv_core #(
        .XLEN     (XLEN)
    ) u_core (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .i_load   (w_accept),
        .i_step   (r_state == c_st_calc),
        .i_is_div (r_op[2]),
        .i_hi     (w_ld_hi),
        .i_lo     (w_ld_lo),
        .i_b      (w_ld_b),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );

    always_comb begin
        w_final = w_lo;
        case (r_op)
            c_f3_mulhu:          w_final = w_hi;
            c_f3_div, c_f3_divu: w_final = r_neg_q ? -w_lo : w_lo;
            c_f3_rem, c_f3_remu: w_final = r_neg_r ? -w_hi : w_hi;
            default:             w_final = w_lo;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
        end else begin
            r_illegal <= w_reject;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_op    <= w_f3;
                        r_neg_q <= !w_dz && (w_rs1_neg ^ w_rs2_neg);
                        r_neg_r <= !w_dz && w_rs1_neg;
                        r_cnt   <= '0;
                        r_state <= w_dz ? c_st_done : c_st_calc;
                    end
                end
                c_st_calc: begin
                    if (flush_i) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    if (!flush_i) begin
                        r_result <= w_final;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy_o    = (r_state != c_st_idle);
    assign done_o    = (r_state == c_st_done) && !flush_i;
    assign illegal_o = r_illegal;
    assign result_o  = done_o ? w_final : r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit against an arithmetic reference model
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [9:0]  funct_i = '0;
    logic [31:0] rs1_i   = '0;
    logic [31:0] rs2_i   = '0;
    logic        busy_o;
    logic        done_o;
    logic        illegal_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(
        .XLEN      (XLEN)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .flush_i   (flush_i),
        .funct_i   (funct_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .illegal_o (illegal_o),
        .result_o  (result_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = {32'b0, a} * {32'b0, b};
        case (f3)
            3'b000:  return p[31:0];
            3'b011:  return p[63:32];
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sbv);
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : 32'(sa % sbv);
            3'b111:  return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation from a negedge; optionally record the expected response
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input string name);
        int n;
        n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait: busy_o got 1 expected 0", name);
        end
        start_i = 1'b1;
        funct_i = {7'b000_0001, f3};
        rs1_i   = a;
        rs2_i   = b;
        if (track) begin
            exp_t e;
            e.res  = ref_model(f3, a, b);
            e.name = name;
            e.due  = cyc + 1 + ((f3[2] && b == 0) ? 0 : XLEN);
            sb.push_back(e);
        end
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_drain_pending"}, 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no pending op", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, result_o, e.res);
                check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        int          n;
        logic [2:0]  legal [6];
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        legal = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

        repeat (3) @(negedge clk_i);
        check("reset_busy",    32'(busy_o),    32'd0);
        check("reset_done",    32'(done_o),    32'd0);
        check("reset_illegal", 32'(illegal_o), 32'd0);
        check("reset_result",  result_o,       32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // MUL 7*6: busy spans the CALC cycles plus the DONE cycle
        issue(3'b000, 32'd7, 32'd6, 1'b1, "mul_7x6");
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        check("mul_busy_cycles", 32'(n), 32'd33);
        check("mul_result_held", result_o, 32'd42);

        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mulhu_max");
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, "rem_m7_2");
        issue(3'b101, 32'd100, 32'd0, 1'b1, "divu_by0");
        issue(3'b111, 32'd100, 32'd0, 1'b1, "remu_by0");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "rem_ovf");
        issue(3'b100, 32'd55, 32'd0, 1'b1, "div_by0");
        drain("directed");

        // Flush at CALC cycle 10 with an ignored start at cycle 5
        issue(3'b101, 32'd1000, 32'd7, 1'b0, "divu_flushed");
        repeat (4) @(negedge clk_i);
        start_i = 1'b1;
        funct_i = {7'b000_0001, 3'b000};
        rs1_i   = 32'd3;
        rs2_i   = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        check("calc_start_ignored_busy", 32'(busy_o), 32'd1);
        repeat (4) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_to_idle", 32'(busy_o), 32'd0);
        issue(3'b101, 32'd1000, 32'd7, 1'b1, "divu_after_flush");
        check("post_flush_accept", 32'(busy_o), 32'd1);
        repeat (3) @(negedge clk_i);
        start_i = 1'b1;
        funct_i = {7'b000_0001, 3'b111};
        rs1_i   = 32'd5;
        rs2_i   = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        drain("flush");

        // Reset in the middle of CALC
        issue(3'b000, 32'd123, 32'd456, 1'b0, "mul_reset");
        repeat (4) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("midreset_busy",    32'(busy_o),    32'd0);
        check("midreset_done",    32'(done_o),    32'd0);
        check("midreset_illegal", 32'(illegal_o), 32'd0);
        check("midreset_result",  result_o,       32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);
        check("post_reset_idle", 32'(busy_o), 32'd0);

        // Unsupported funct values
        start_i = 1'b1;
        funct_i = {7'b000_0001, 3'b001};
        @(negedge clk_i);
        start_i = 1'b0;
        check("illegal_mulh_pulse", 32'(illegal_o), 32'd1);
        check("illegal_mulh_busy",  32'(busy_o),    32'd0);
        @(negedge clk_i);
        check("illegal_pulse_end",  32'(illegal_o), 32'd0);
        start_i = 1'b1;
        funct_i = {7'b010_0000, 3'b000};
        @(negedge clk_i);
        start_i = 1'b0;
        check("illegal_funct7_pulse", 32'(illegal_o), 32'd1);
        check("illegal_funct7_busy",  32'(busy_o),    32'd0);
        @(negedge clk_i);

        for (int i = 0; i < 40; i++) begin
            f3 = legal[$urandom_range(0, 5)];
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            issue(f3, a, b, 1'b1, $sformatf("rand%0d_f%0d", i, f3));
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (legal values 8..64, power of two).
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN)+1, meaning iteration counter width.
REQ-003 SHALL have port clk_i  input  1  meaning single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  meaning request to begin an operation.
REQ-006 SHALL have port flush_i  input  1  meaning abort of any in-flight operation (pipeline flush).
REQ-007 SHALL have port funct_i  input  10  meaning {funct7, funct3} of the issuing instruction.
REQ-008 SHALL have port rs1_i  input  XLEN  meaning multiplicand or dividend.
REQ-009 SHALL have port rs2_i  input  XLEN  meaning multiplier or divisor.
REQ-010 SHALL have port busy_o  output  1  meaning unit occupied; the pipeline stalls on it.
REQ-011 SHALL have port done_o  output  1  meaning one-cycle pulse, result_o valid.
REQ-012 SHALL have port illegal_o  output  1  meaning one-cycle pulse, start rejected for an unsupported funct.
REQ-013 SHALL have port result_o  output  XLEN  meaning operation result.

Function
REQ-014 SHALL accept an operation only in IDLE with start_i=1, flush_i=0, funct7=7'b000_0001, and funct3 in {000 MUL, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU}; rs1_i, rs2_i and funct_i are latched on that edge (E0).
REQ-015 SHALL, on start in IDLE with funct7 != 7'b000_0001 or funct3 in {001, 010}, remain in IDLE and pulse illegal_o in the next cycle.
REQ-016 SHALL ignore start_i while not in IDLE.
REQ-017 SHALL implement FSM states IDLE, CALC, DONE: IDLE->CALC on accept; CALC->DONE after exactly XLEN iterations; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL assert busy_o in CALC and DONE; done_o only in DONE.
REQ-019 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per CALC cycle; the done_o cycle is entered at edge E0+XLEN.
REQ-020 SHALL produce MUL = low XLEN bits of rs1*rs2 and MULHU = high XLEN bits of the unsigned 2*XLEN product.
REQ-021 SHALL for DIV/REM divide magnitudes and apply signs in DONE: quotient negative iff operand signs differ; remainder takes the dividend sign.
REQ-022 SHALL for divisor zero go IDLE->DONE directly at E0 with quotient all ones and remainder = rs1.
REQ-023 SHALL for DIV of the most-negative value by -1 return the most-negative value; REM returns 0.
REQ-024 SHALL hold result_o stable from DONE until the next accepted operation's DONE.
REQ-025 SHALL on flush_i=1 in CALC or DONE return to IDLE on the next edge with no done_o pulse; result_o keeps its prior value.
REQ-026 SHALL give flush_i priority over start_i when both are asserted in IDLE (no accept).

Reset
REQ-027 SHALL on rst_i=0, asynchronously, force state IDLE, busy_o=0, done_o=0, illegal_o=0, result_o=0, counter=0.
REQ-028 SHALL abandon any in-flight operation on reset mid-operation, with no done_o after release.

Structure
REQ-029 SHALL place the funct7 M-extension constant, funct3 op encodings, the FSM state typedef, and the ALU-control code ALUCtrl_mul=4'b0111 in shared package muldiv_pkg.
REQ-030 SHALL instantiate one sub-module, muldiv_core, holding the iterative accumulator/shift datapath; the FSM, counter, and sign fix-up stay in muldiv_unit.

Verification
REQ-031 SHALL cover: XLEN=32, MUL rs1=7 rs2=6 -> done_o 32 cycles after accept, result_o=42, busy_o high 33 cycles.
REQ-032 SHALL cover: MULHU rs1=32'hFFFF_FFFF rs2=32'hFFFF_FFFF -> result_o=32'hFFFF_FFFE.
REQ-033 SHALL cover: DIV rs1=-7 rs2=2 -> result_o=-3 (32'hFFFF_FFFD); REM same operands -> -1.
REQ-034 SHALL cover: DIVU rs1=100 rs2=0 -> done_o one cycle after accept, result_o=32'hFFFF_FFFF; REMU -> 100; DIV 32'h8000_0000 by -1 -> 32'h8000_0000.
REQ-035 SHALL cover: flush_i at CALC cycle 10 of DIVU -> IDLE next edge, no done_o, new start accepted the following cycle; start during CALC ignored.
REQ-036 SHALL cover: rst_i low at CALC cycle 5 -> all outputs 0 immediately; funct_i={7'b0000001,3'b001} start -> illegal_o pulse, busy_o stays 0.
